// File: rtl/proc_pkg.sv
// Shared processor-side definitions: word width, default key debounce length
// and the IN request FSM encoding.
package proc_pkg;

  localparam int DATA_W                  = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    ACK        = 2'd2,
    DROP       = 2'd3
  } in_state_e;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stable-sample
// debounce down-counter and a one-cycle press pulse on a debounced 1->0 edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic iRST_N,
  input  logic key_n,
  output logic press
);

  logic        key_s1, key_s2;
  logic        db_q, db_prev;
  logic [15:0] cnt_q;

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Counter reloads whenever the synchronized level matches the debounced one,
  // so any bounce back restarts the stability window.
  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else if (key_s2 == db_q) begin
      cnt_q <= 16'(DEBOUNCE_CYCLES - 1);
    end else if (cnt_q == '0) begin
      db_q  <= key_s2;
      cnt_q <= 16'(DEBOUNCE_CYCLES - 1);
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      db_prev <= 1'b1;
      press   <= 1'b0;
    end else begin
      db_prev <= db_q;
      press   <= db_prev & ~db_q;
    end
  end

endmodule

// File: rtl/in_switch_capture.sv
// IN-instruction switch capture: debounced Enter press returns the switch word
// via req/ack. Optional 1-entry press buffer when IN_PRESS_BUFFER_EN is defined.
module in_switch_capture
  import proc_pkg::*;
#(
  parameter int DATA_W          = proc_pkg::DATA_W,
  parameter int DEBOUNCE_CYCLES = proc_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] sw,
  input  logic              key_enter,
  input  logic              in_req,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic              waiting,
  output logic              lost
);

  // state      | meaning
  // IDLE       | no request being serviced
  // WAIT_PRESS | request outstanding, waiting for Enter
  // ACK        | in_ack pulse, in_data freshly loaded
  // DROP       | waiting for in_req to fall before the next request

  in_state_e         state_q, state_d;
  logic [DATA_W-1:0] sw_s1, sw_s2;
  logic              press;
  logic              load_data, use_buf, stray, lost_set;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clock (clock),
    .iRST_N(iRST_N),
    .key_n (key_enter),
    .press (press)
  );

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_data = 1'b0;
    use_buf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req) begin
          if (buf_valid) begin
            state_d   = ACK;
            load_data = 1'b1;
            use_buf   = 1'b1;
          end else if (press) begin
            state_d   = ACK;
            load_data = 1'b1;
          end else begin
            state_d = WAIT_PRESS;
          end
        end
      end
      WAIT_PRESS: begin
        if (!in_req) begin
          state_d = IDLE;
        end else if (press) begin
          state_d   = ACK;
          load_data = 1'b1;
        end
      end
      ACK:     state_d = DROP;
      DROP:    if (!in_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A press not consumed by this cycle's transition goes to the buffer or is lost.
  assign stray = press & ~(load_data & ~use_buf);

`ifdef IN_PRESS_BUFFER_EN
  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      if (use_buf) buf_valid <= 1'b0;
      if (stray && (!buf_valid || use_buf)) begin
        buf_valid <= 1'b1;
        buf_data  <= sw_s2;
      end
    end
  end
  assign lost_set = stray & buf_valid & ~use_buf;
`else
  assign buf_valid = 1'b0;
  assign buf_data  = '0;
  assign lost_set  = stray;
`endif

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      in_data <= '0;
      lost    <= 1'b0;
    end else begin
      if (load_data) in_data <= use_buf ? buf_data : sw_s2;
      if (lost_set)  lost    <= 1'b1;
    end
  end

  assign in_ack  = (state_q == ACK);
  assign waiting = (state_q == WAIT_PRESS);

endmodule

// File: doc/in_switch_capture.md
# in_switch_capture

Input-side counterpart to the LCD output path: it serves the processor's IN instruction by capturing a 16-bit value from the board switches when the user presses the Enter key. It synchronizes and debounces the key, then returns the captured value through a request/acknowledge handshake. It also raises a `waiting` flag so the BIOS/SO display logic can show that the CPU is stalled on input. It sits between the board pins (SW, KEY) and the processor datapath's IN mux.

## Interface
Parameters:
- `DATA_W`, 16: width of the switch bus and returned value.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples required to accept a key level change; legal range 1..65535.

Ports:
- `clock` in 1: processor clock; the only clock.
- `iRST_N` in 1: asynchronous, active-low reset.
- `sw` in DATA_W: raw switch levels, asynchronous to `clock`.
- `key_enter` in 1: raw Enter push-button; active-low (0 = pressed).
- `in_req` in 1: level request from the IN instruction; held high until `in_ack`.
- `in_ack` out 1: one-cycle pulse; `in_data` is valid in the same cycle.
- `in_data` out DATA_W: captured switch value; holds its last value between acks.
- `waiting` out 1: high while a request is outstanding and no data is available.
- `lost` out 1: sticky; a press was discarded. Cleared only by reset.

## Operation
- **Key path**
  - 2-flop synchronizer on `key_enter` and on each `sw` bit.
  - The debounce counter restarts on every change of the synchronized key.
  - The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal samples.
  - A debounced 1→0 transition produces a one-cycle `press` pulse.
  - On `press`, the synchronized `sw` is captured as `cap`.
- **Request FSM states**
  - **IDLE**
    - `in_req`=1 with buffer valid → ACK (buffered data); buffer cleared.
    - `in_req`=1 with `press` in the same cycle → ACK (`cap`).
    - `in_req`=1 otherwise → WAIT_PRESS.
  - **WAIT_PRESS**
    - `waiting`=1.
    - `press` → ACK (`cap`).
    - `in_req`=0 (abort) → IDLE, and nothing is acked.
  - **ACK**
    - `in_ack`=1 and `in_data` is loaded for exactly one cycle.
    - Next state is DROP.
  - **DROP**
    - Waits for `in_req`=0, then → IDLE.
    - A new request is not serviced until `in_req` has been low for at least one cycle.
- **Press outside WAIT_PRESS** (IDLE without a same-cycle request, ACK, or DROP): handled per Configuration.
- **Width rule**: `in_data` is exactly DATA_W bits wide, with no sign or BCD conversion; the display side does the BCD.

## Timing
- **Reset values**: `in_ack`=0, `in_data`=0, `waiting`=0, `lost`=0, FSM=IDLE, debounced key=1 (released), buffer empty, counter=0.
- **Key latency**: raw edge → `press` = 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- **WAIT_PRESS**: `in_ack` asserts the cycle after `press`.
- **IDLE with buffer valid**: `in_ack` asserts the cycle after `in_req` is first sampled high.
- **Waiting flag**: `waiting` rises the cycle after `in_req` is sampled high in IDLE with no data available. It falls in the same cycle that `in_ack` rises, or the cycle after an abort.
- **Glitch rejection**: glitches shorter than `DEBOUNCE_CYCLES` never produce `press`.
- **Held key**: a held key produces a single `press`; a new one requires a debounced release and a debounced re-press.
- **Reset mid-operation**: all state returns to reset values immediately; a pending buffer is discarded.

## Configuration
- **`IN_PRESS_BUFFER_EN` defined**: a 1-entry buffer holds a press that arrives outside WAIT_PRESS.
  - A press while the buffer is already full is dropped; the buffer keeps the older value and `lost` is set.
  - Buffered data is consumed by the next request.
- **Undefined**: no buffer; every press outside WAIT_PRESS is dropped and sets `lost`.
  - In IDLE, a request always goes to WAIT_PRESS unless `press` occurs in the same cycle.

## Structure
- **Shared package `proc_pkg`**:
  - FSM state encoding constants IDLE/WAIT_PRESS/ACK/DROP.
  - Default `DEBOUNCE_CYCLES`.
  - `DATA_W` = processor word width (16).
- **Sub-module `key_debounce`**: synchronizer + counter + edge detector; outputs `press`. It is reusable for other KEY inputs.
- **Top module**: `sw` sync, capture register, buffer, FSM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset values**: assert `iRST_N`=0 mid-cycle → all outputs 0, `in_data`=0x0000, FSM IDLE, with no clock edge needed.
2. **Basic request**: `sw`=0x1234, `in_req`=1, key pressed 10 cycles → `waiting`=1, then `in_ack` pulses once with `in_data`=0x1234 at raw edge + 8 cycles; `waiting`=0 in the same cycle.
3. **Bounce rejection**: key toggles every 2 cycles for 20 cycles, then held → exactly one `in_ack`, and only after the key has been stable for 4 cycles.
4. **Buffered press (macro on)**:
   - Press with `sw`=0x00FF while idle, then `in_req`=1 → `in_ack` the next cycle with 0x00FF, and `waiting` never rises.
   - A second idle press while the buffer is full → `lost`=1 and the buffer still returns 0x00FF.
5. **Early press (macro off)**: press while idle → `lost`=1; a later `in_req` waits in WAIT_PRESS for a new press.
6. **Abort and re-request**:
   - Drop `in_req` during WAIT_PRESS → IDLE, `waiting`=0, no ack.
   - Hold `in_req` high after an ack → no second ack until `in_req` has been 0 for at least 1 cycle.
